// File: rtl/crc16_chk_ctrl_if.sv
// ---------------------------------------------------------------------------
// crc16_chk_ctrl_if
// Groups the two handshake channels of the CRC16 check sequencer:
//   rx_*  : framed byte stream from the receive path (valid/ready, rx_last
//           marks the final byte of a frame)
//   res_* : per-frame pass/fail result to downstream (valid/ready)
// Modports:
//   slave  : the sequencer (consumes bytes, produces results)
//   master : the environment (produces bytes, consumes results)
// ---------------------------------------------------------------------------
interface crc16_chk_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_last;
    logic       rx_ready;
    logic       res_valid;
    logic       res_ready;
    logic       res_err;
    logic       res_len_err;

    modport slave (
        input  rx_valid, rx_byte, rx_last, res_ready,
        output rx_ready, res_valid, res_err, res_len_err
    );

    modport master (
        output rx_valid, rx_byte, rx_last, res_ready,
        input  rx_ready, res_valid, res_err, res_len_err
    );
endinterface

// File: rtl/crc16_chk_ctrl.sv
// ---------------------------------------------------------------------------
// crc16_chk_ctrl
// Sequencer for the crc16_chk datapath. Collects 8 data bytes plus 2 CRC
// bytes, presents them on crc16_DI/crc16_I, pulses crc16_enable for one
// cycle, waits CHK_LAT cycles, captures crc16_err and hands the result
// downstream. Frames whose length is not 10 bytes are reported with
// res_len_err and never reach the checker.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   bus             rx_* byte stream in, res_* result out (slave modport)
//   crc16_enable    one-cycle start pulse to the checker
//   crc16_DI/I      assembled data word / received CRC (held between frames)
//   crc16_err       checker mismatch flag, sampled CHK_LAT cycles after enable
//   frm_cnt         delivered results (wrapping)
//   err_cnt         results with any error flag (saturating)
//   busy            high whenever not IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module crc16_chk_ctrl #(
    parameter int CHK_LAT   = 1,
    parameter int ERR_CNT_W = 8,
    parameter int FRM_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    crc16_chk_ctrl_if.slave      bus,
    output logic                 crc16_enable,
    output logic [63:0]          crc16_DI,
    output logic [15:0]          crc16_I,
    input  logic                 crc16_err,
    output logic [FRM_CNT_W-1:0] frm_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);
    localparam int LAT_W = (CHK_LAT < 2) ? 1 : $clog2(CHK_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_DRAIN   = 3'd2,
        S_FIRE    = 3'd3,
        S_WAIT    = 3'd4,
        S_REPORT  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [63:0]          di_q, di_d;
    logic [15:0]          i_q, i_d;
    logic                 res_err_q, res_err_d;
    logic                 res_len_err_q, res_len_err_d;
    logic [FRM_CNT_W-1:0] frm_cnt_q, frm_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 res_valid_q, res_valid_d;
    logic                 enable_q, enable_d;
    logic                 busy_q, busy_d;
    logic                 acc_s;

    // Saturating increment for the error statistic.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + ERR_CNT_W'(1);
        end
    endfunction

    // Next-state, datapath capture and registered-output decode.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        lat_d         = lat_q;
        di_d          = di_q;
        i_d           = i_q;
        res_err_d     = res_err_q;
        res_len_err_d = res_len_err_q;
        frm_cnt_d     = frm_cnt_q;
        err_cnt_d     = err_cnt_q;
        // rx_ready_q mirrors the current state, so this is the accept strobe.
        acc_s         = bus.rx_valid & rx_ready_q;

        case (state_q)
            S_IDLE: begin
                if (acc_s) begin
                    di_d[63:56] = bus.rx_byte;
                    if (bus.rx_last) begin
                        // One-byte frame: report without running the checker.
                        res_len_err_d = 1'b1;
                        res_err_d     = 1'b0;
                        state_d       = S_REPORT;
                    end else begin
                        idx_d   = 4'd1;
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (acc_s) begin
                    case (idx_q)
                        4'd0:    di_d[63:56] = bus.rx_byte;
                        4'd1:    di_d[55:48] = bus.rx_byte;
                        4'd2:    di_d[47:40] = bus.rx_byte;
                        4'd3:    di_d[39:32] = bus.rx_byte;
                        4'd4:    di_d[31:24] = bus.rx_byte;
                        4'd5:    di_d[23:16] = bus.rx_byte;
                        4'd6:    di_d[15:8]  = bus.rx_byte;
                        4'd7:    di_d[7:0]   = bus.rx_byte;
                        4'd8:    i_d[15:8]   = bus.rx_byte;
                        4'd9:    i_d[7:0]    = bus.rx_byte;
                        default: di_d        = di_q;
                    endcase
                    if (bus.rx_last) begin
                        if (idx_q == 4'd9) begin
                            state_d = S_FIRE;
                        end else begin
                            res_len_err_d = 1'b1;
                            res_err_d     = 1'b0;
                            state_d       = S_REPORT;
                        end
                    end else if (idx_q == 4'd9) begin
                        // Frame is already too long; swallow the rest.
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_DRAIN: begin
                if (acc_s && bus.rx_last) begin
                    res_len_err_d = 1'b1;
                    res_err_d     = 1'b0;
                    state_d       = S_REPORT;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FIRE: begin
                lat_d   = LAT_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // lat_q counts cycles since FIRE; the checker result is valid
                // on the cycle where it equals CHK_LAT.
                if (lat_q == LAT_W'(CHK_LAT)) begin
                    res_err_d     = crc16_err;
                    res_len_err_d = 1'b0;
                    state_d       = S_REPORT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_REPORT: begin
                if (bus.res_ready) begin
                    frm_cnt_d = frm_cnt_q + FRM_CNT_W'(1);
                    if (res_err_q || res_len_err_q) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    res_err_d     = 1'b0;
                    res_len_err_d = 1'b0;
                    idx_d         = 4'd0;
                    state_d       = S_IDLE;
                end else begin
                    state_d = S_REPORT;
                end
            end
            default: begin
                idx_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase

        rx_ready_d  = (state_d == S_IDLE) || (state_d == S_COLLECT) || (state_d == S_DRAIN);
        enable_d    = (state_d == S_FIRE);
        res_valid_d = (state_d == S_REPORT);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= 4'd0;
            lat_q         <= '0;
            di_q          <= 64'd0;
            i_q           <= 16'd0;
            res_err_q     <= 1'b0;
            res_len_err_q <= 1'b0;
            frm_cnt_q     <= '0;
            err_cnt_q     <= '0;
            rx_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            enable_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            lat_q         <= lat_d;
            di_q          <= di_d;
            i_q           <= i_d;
            res_err_q     <= res_err_d;
            res_len_err_q <= res_len_err_d;
            frm_cnt_q     <= frm_cnt_d;
            err_cnt_q     <= err_cnt_d;
            rx_ready_q    <= rx_ready_d;
            res_valid_q   <= res_valid_d;
            enable_q      <= enable_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.rx_ready    = rx_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_err     = res_err_q;
    assign bus.res_len_err = res_len_err_q;
    assign crc16_enable    = enable_q;
    assign crc16_DI        = di_q;
    assign crc16_I         = i_q;
    assign frm_cnt         = frm_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_crc16_chk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_crc16_chk_ctrl
// Directed bench for crc16_chk_ctrl: drives frames through the rx channel,
// pushes the expected result flags to a scoreboard queue, and pops/compares
// when the result handshake completes. A monitor records checker start
// pulses so that enable count, timing and presented DI/I can be checked.
// ---------------------------------------------------------------------------
module tb_crc16_chk_ctrl;
    localparam int CHK_LAT = 1;

    typedef struct packed {
        logic err;
        logic len;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crc16_enable;
    logic [63:0] crc16_DI;
    logic [15:0] crc16_I;
    logic        crc16_err;
    logic [15:0] frm_cnt;
    logic [7:0]  err_cnt;
    logic        busy;

    crc16_chk_ctrl_if bus();

    crc16_chk_ctrl #(.CHK_LAT(CHK_LAT), .ERR_CNT_W(8), .FRM_CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .crc16_enable (crc16_enable),
        .crc16_DI     (crc16_DI),
        .crc16_I      (crc16_I),
        .crc16_err    (crc16_err),
        .frm_cnt      (frm_cnt),
        .err_cnt      (err_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          tests     = 0;
    int          fails     = 0;
    int          cyc       = 0;
    int          last_acc  = 0;
    int          en_cnt    = 0;
    int          en_cyc    = 0;
    int          en_double = 0;
    logic        en_prev   = 1'b0;
    logic [63:0] en_di     = 64'd0;
    logic [15:0] en_i      = 16'd0;
    int          exp_en    = 0;
    int          exp_frm   = 0;
    int          exp_errc  = 0;
    logic [7:0]  frm_b [0:15];
    res_t        sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Checker start-pulse monitor, sampled just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (crc16_enable === 1'b1) begin
            en_cnt = en_cnt + 1;
            en_cyc = cyc;
            en_di  = crc16_DI;
            en_i   = crc16_I;
            if (en_prev) en_double = en_double + 1;
        end
        en_prev = (crc16_enable === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        bus.rx_last  = last;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rx_ready_wait", 80'(n < 50), 80'd1);
        last_acc = cyc;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
    endtask

    task automatic send_frame(input int n);
        for (int k = 0; k < n; k++) send_byte(frm_b[k], k == n - 1);
    endtask

    task automatic get_result(input int hold, input int exp_lat);
        int   n;
        res_t e;
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_wait", 80'(n < 50), 80'd1);
        if (exp_lat >= 0) chk("res_latency", 80'(cyc - last_acc), 80'(exp_lat));
        chk("sb_nonempty", 80'(sb.size() > 0), 80'd1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        for (int k = 0; k < hold; k++) begin
            chk("hold_valid",    80'(bus.res_valid), 80'd1);
            chk("hold_err",      80'(bus.res_err),   80'(e.err));
            chk("hold_rx_ready", 80'(bus.rx_ready),  80'd0);
            chk("hold_frm_cnt",  80'(frm_cnt),       80'(exp_frm));
            @(negedge clk);
        end
        chk("res_err",     80'(bus.res_err),     80'(e.err));
        chk("res_len_err", 80'(bus.res_len_err), 80'(e.len));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        exp_frm = (exp_frm + 1) % 65536;
        if ((e.err || e.len) && exp_errc < 255) exp_errc++;
        chk("frm_cnt",        80'(frm_cnt),       80'(exp_frm));
        chk("err_cnt",        80'(err_cnt),       80'(exp_errc));
        chk("post_res_valid", 80'(bus.res_valid), 80'd0);
        chk("post_busy",      80'(busy),          80'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 80'({bus.rx_ready, bus.res_valid, bus.res_err, bus.res_len_err, crc16_enable, busy}), 80'd0);
        chk({tag, "_di"},  80'(crc16_DI), 80'd0);
        chk({tag, "_i"},   80'(crc16_I),  80'd0);
        chk({tag, "_cnt"}, 80'({frm_cnt, err_cnt}), 80'd0);
    endtask

    task automatic chk_fire(input logic [63:0] di, input logic [15:0] i);
        exp_en++;
        chk("en_count", 80'(en_cnt), 80'(exp_en));
        chk("en_cycle", 80'(en_cyc - last_acc), 80'd1);
        chk("en_di",    80'(en_di), 80'(di));
        chk("en_i",     80'(en_i),  80'(i));
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'd0;
        bus.rx_last   = 1'b0;
        bus.res_ready = 1'b0;
        crc16_err     = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Good frame, checker reports no error.
        for (int k = 0; k < 8; k++) frm_b[k] = 8'hFF;
        frm_b[8] = 8'h55;
        frm_b[9] = 8'h65;
        crc16_err = 1'b0;
        send_frame(10);
        sb.push_back('{err: 1'b0, len: 1'b0});
        get_result(0, 2 + CHK_LAT);
        chk_fire(64'hFFFF_FFFF_FFFF_FFFF, 16'h5565);

        // Same frame, checker reports mismatch.
        crc16_err = 1'b1;
        send_frame(10);
        sb.push_back('{err: 1'b1, len: 1'b0});
        get_result(0, 2 + CHK_LAT);
        chk_fire(64'hFFFF_FFFF_FFFF_FFFF, 16'h5565);

        // Short frame: length error, no checker run, crc16_err ignored.
        for (int k = 0; k < 5; k++) frm_b[k] = 8'hA0 + 8'(k);
        send_frame(5);
        sb.push_back('{err: 1'b0, len: 1'b1});
        get_result(0, -1);
        chk("short_no_en", 80'(en_cnt), 80'(exp_en));

        // Long frame: bytes 10-11 drained, DI/I hold bytes 0-9.
        for (int k = 0; k < 12; k++) frm_b[k] = 8'h10 + 8'(k);
        send_frame(12);
        sb.push_back('{err: 1'b0, len: 1'b1});
        get_result(0, -1);
        chk("long_no_en", 80'(en_cnt), 80'(exp_en));
        chk("long_di", 80'(crc16_DI), 80'(64'h1011_1213_1415_1617));
        chk("long_i",  80'(crc16_I),  80'(16'h1819));

        // Downstream stalls 5 cycles in REPORT.
        for (int k = 0; k < 10; k++) frm_b[k] = 8'h30 + 8'(k);
        crc16_err = 1'b1;
        send_frame(10);
        sb.push_back('{err: 1'b1, len: 1'b0});
        get_result(5, 2 + CHK_LAT);
        chk_fire(64'h3031_3233_3435_3637, 16'h3839);

        // Reset while waiting on the checker: pending result discarded.
        crc16_err = 1'b0;
        for (int k = 0; k < 10; k++) frm_b[k] = 8'h40 + 8'(k);
        send_frame(10);
        @(negedge clk);
        exp_en++;
        chk("wait_busy", 80'(busy), 80'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_in_wait");
        rst = 1'b0;
        exp_frm  = 0;
        exp_errc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_no_res", 80'({bus.res_valid, busy}), 80'd0);
        end

        // 256 bad two-byte frames: err_cnt saturates.
        for (int f = 0; f < 256; f++) begin
            frm_b[0] = 8'(f);
            frm_b[1] = 8'hEE;
            send_frame(2);
            sb.push_back('{err: 1'b0, len: 1'b1});
            get_result(0, -1);
        end
        chk("sat_err_cnt", 80'(err_cnt), 80'(8'hFF));
        chk("sat_frm_cnt", 80'(frm_cnt), 80'd256);
        chk("en_total",    80'(en_cnt),  80'(exp_en));
        chk("en_one_cycle", 80'(en_double), 80'd0);
        chk("sb_empty",    80'(sb.size()), 80'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
